// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo block: FSM encodings,
// echo-mode selectors and the ASCII case-swap transform.
package uart_pkg;

  localparam int MODE_VERBATIM  = 0;
  localparam int MODE_CASE_SWAP = 1;

  typedef enum logic [1:0] {
    R_INIT,
    R_REL,
    R_WAIT,
    R_ACK
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_WR,
    T_HOLD
  } tx_state_e;

  // Flip bit 5 only for letters; every other code passes through untouched.
  function automatic logic [7:0] case_swap(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A))
      return c ^ 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// Echo FIFO: DEPTH-entry character store with wrapping pointers and an
// occupancy counter. Simultaneous push and pop are accepted even when full.
module echo_fifo
  import uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/gen_uart_echo.sv
// UART echo: a receive FSM hands characters from rcvr into echo_fifo, and a
// transmit FSM drains the FIFO into txmit, optionally case-swapping letters.
module gen_uart_echo
  import uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int MODE  = MODE_VERBATIM
) (
  input  logic                   CLK,
  input  logic                   BTND,
  input  logic [DW-1:0]          rbr,
  input  logic                   rdrdy,
  output logic                   rdrst,
  output logic [DW-1:0]          tdin,
  input  logic                   tbuf,
  output logic                   wrn,
  input  logic                   clr_ovf,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf
);

  rx_state_e     r_state_q, r_state_d;
  tx_state_e     t_state_q, t_state_d;
  logic          rdrst_q, rdrst_d;
  logic          wrn_q, wrn_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] tdin_q, tdin_d;
  logic          push, pop, drop;
  logic [DW-1:0] head, head_xf;

  echo_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (BTND),
    .push    (push),
    .pop     (pop),
    .wr_data (rbr),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  generate
    if (MODE == MODE_CASE_SWAP && DW == 8) begin : g_swap
      assign head_xf = case_swap(head);
    end else begin : g_plain
      assign head_xf = head;
    end
  endgenerate

  // Receive side. rdrst is registered so reset can hold it low while the
  // FSM sits in R_INIT; the strobe follows R_INIT/R_ACK by one cycle.
  always_comb begin
    r_state_d = r_state_q;
    push      = 1'b0;
    drop      = 1'b0;
    case (r_state_q)
      R_INIT: r_state_d = R_REL;
      R_REL:  r_state_d = R_WAIT;
      R_WAIT: begin
        if (rdrdy) begin
          r_state_d = R_ACK;
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
      end
      R_ACK:  r_state_d = R_REL;
      default: r_state_d = R_INIT;
    endcase
    rdrst_d = (r_state_q == R_INIT) || (r_state_q == R_ACK);
    ovf_d   = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Transmit side. wrn is registered off T_WR, giving a clean one-cycle strobe.
  always_comb begin
    t_state_d = t_state_q;
    pop       = 1'b0;
    tdin_d    = tdin_q;
    wrn_d     = 1'b0;
    case (t_state_q)
      T_IDLE: if (!empty && !tbuf) t_state_d = T_LOAD;
      T_LOAD: begin
        pop       = 1'b1;
        tdin_d    = head_xf;
        t_state_d = T_WR;
      end
      T_WR: begin
        wrn_d     = 1'b1;
        t_state_d = T_HOLD;
      end
      T_HOLD: if (!tbuf) t_state_d = T_IDLE;
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge BTND) begin
    if (BTND) begin
      r_state_q <= R_INIT;
      t_state_q <= T_IDLE;
      rdrst_q   <= 1'b0;
      wrn_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tdin_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      t_state_q <= t_state_d;
      rdrst_q   <= rdrst_d;
      wrn_q     <= wrn_d;
      ovf_q     <= ovf_d;
      tdin_q    <= tdin_d;
    end
  end

  assign rdrst = rdrst_q;
  assign wrn   = wrn_q;
  assign ovf   = ovf_q;
  assign tdin  = tdin_q;

endmodule

// File: tb/tb_gen_uart_echo.sv
// Directed bench for gen_uart_echo: a verbatim and a case-swap instance
// share all inputs; the rcvr handshake is modelled inline.
module tb_gen_uart_echo;

  logic       CLK = 1'b0;
  logic       BTND;
  logic [7:0] rbr;
  logic       rdrdy, tbuf, clr_ovf;

  logic       rdrst0, wrn0, empty0, full0, ovf0;
  logic [7:0] tdin0;
  logic [4:0] count0;
  logic       rdrst1, wrn1, empty1, full1, ovf1;
  logic [7:0] tdin1;
  logic [4:0] count1;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap0[$];
  logic [7:0] cap1[$];

  always #5 CLK = ~CLK;

  gen_uart_echo #(.DW(8), .DEPTH(16), .MODE(0)) dut (
    .CLK(CLK), .BTND(BTND), .rbr(rbr), .rdrdy(rdrdy), .rdrst(rdrst0),
    .tdin(tdin0), .tbuf(tbuf), .wrn(wrn0), .clr_ovf(clr_ovf),
    .count(count0), .empty(empty0), .full(full0), .ovf(ovf0)
  );

  gen_uart_echo #(.DW(8), .DEPTH(16), .MODE(1)) dut_swap (
    .CLK(CLK), .BTND(BTND), .rbr(rbr), .rdrdy(rdrdy), .rdrst(rdrst1),
    .tdin(tdin1), .tbuf(tbuf), .wrn(wrn1), .clr_ovf(clr_ovf),
    .count(count1), .empty(empty1), .full(full1), .ovf(ovf1)
  );

  always @(negedge CLK) begin
    if (wrn0) cap0.push_back(tdin0);
    if (wrn1) cap1.push_back(tdin1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One rcvr character: raise rdrdy, drop it once rdrst acknowledges.
  task automatic send_char(input logic [7:0] c, input logic with_clr);
    logic got;
    tick();
    rbr     = c;
    rdrdy   = 1'b1;
    clr_ovf = with_clr;
    got     = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      clr_ovf = 1'b0;
      if (rdrst0) got = 1'b1;
    end
    rdrdy = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL handshake char=%h rdrst_seen=%b required 1", c, got);
    end
  endtask

  task automatic test_reset();
    BTND = 1'b1; rbr = '0; rdrdy = 1'b0; tbuf = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    checks++;
    if ({rdrst0, wrn0, ovf0, empty0, full0} !== 5'b00010 || count0 !== 5'd0 || tdin0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold rdrst=%b wrn=%b ovf=%b empty=%b full=%b count=%0d tdin=%h required 0 0 0 1 0 0 00",
               rdrst0, wrn0, ovf0, empty0, full0, count0, tdin0);
    end
    BTND = 1'b0;
    #3;
    checks++;
    if (rdrst0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdrst got=%b required 0", rdrst0);
    end
    tick();
    checks++;
    if (rdrst0 !== 1'b1) begin
      errors++;
      $display("FAIL init_rdrst_pulse got=%b required 1", rdrst0);
    end
    tick();
    checks++;
    if (rdrst0 !== 1'b0 || count0 !== 5'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL init_rdrst_release rdrst=%b count=%0d empty=%b ovf=%b required 0 0 1 0",
               rdrst0, count0, empty0, ovf0);
    end
    repeat (3) tick();
  endtask

  task automatic test_latency();
    int first, highs;
    logic [7:0] t0, t1;
    first = 0; highs = 0; t0 = '0; t1 = '0;
    tick();
    rbr = 8'h41; rdrdy = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (rdrst0) rdrdy = 1'b0;
      if (wrn0) begin
        highs++;
        if (first == 0) begin first = n; t0 = tdin0; t1 = tdin1; end
      end
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL latency cycles=%0d required 4", first);
    end
    checks++;
    if (highs !== 1) begin
      errors++;
      $display("FAIL wrn_width cycles_high=%0d required 1", highs);
    end
    checks++;
    if (t0 !== 8'h41) begin
      errors++;
      $display("FAIL verbatim_tdin got=%h required 41", t0);
    end
    checks++;
    if (t1 !== 8'h61) begin
      errors++;
      $display("FAIL swap_tdin got=%h required 61", t1);
    end
  endtask

  task automatic test_case_swap();
    logic [7:0] stim [8] = '{8'h61, 8'h5A, 8'h31, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A};
    logic [7:0] expv [8] = '{8'h41, 8'h7A, 8'h31, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h5A};
    cap0.delete(); cap1.delete();
    for (int i = 0; i < 8; i++) send_char(stim[i], 1'b0);
    repeat (20) tick();
    checks++;
    if (cap1.size() !== 8 || cap0.size() !== 8) begin
      errors++;
      $display("FAIL swap_count swap=%0d verbatim=%0d required 8 8", cap1.size(), cap0.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap1[i] !== expv[i] || cap0[i] !== stim[i]) begin
          errors++;
          $display("FAIL swap_char[%0d] swap=%h verbatim=%h required %h %h",
                   i, cap1[i], cap0[i], expv[i], stim[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic got;
    tbuf = 1'b1;
    for (int i = 0; i < 16; i++) send_char(8'h30 + 8'(i), 1'b0);
    checks++;
    if (count0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL fill16 count=%0d full=%b ovf=%b required 16 1 0", count0, full0, ovf0);
    end
    send_char(8'h40, 1'b0);
    checks++;
    if (count0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL overflow17 count=%0d full=%b ovf=%b required 16 1 1", count0, full0, ovf0);
    end
    // Release tbuf for exactly one load so the pop lands with a new push.
    tbuf = 1'b0;
    tick();
    rbr = 8'h50; rdrdy = 1'b1; tbuf = 1'b1;
    tick();
    checks++;
    if (count0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL pop_push_full count=%0d full=%b ovf=%b required 16 1 1", count0, full0, ovf0);
    end
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (rdrst0) got = 1'b1;
    end
    rdrdy = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf got=%b required 0", ovf0);
    end
    send_char(8'h51, 1'b1);
    checks++;
    if (ovf0 !== 1'b1 || count0 !== 5'd16) begin
      errors++;
      $display("FAIL clr_with_overflow ovf=%b count=%0d required 1 16", ovf0, count0);
    end
    cap0.delete(); cap1.delete();
    tbuf = 1'b0;
    repeat (90) tick();
    checks++;
    if (cap0.size() !== 16 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL drain_count got=%0d empty=%b required 16 1", cap0.size(), empty0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] e;
        e = (i < 15) ? 8'h31 + 8'(i) : 8'h50;
        checks++;
        if (cap0[i] !== e) begin
          errors++;
          $display("FAIL drain_char[%0d] got=%h required %h", i, cap0[i], e);
        end
      end
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    tbuf = 1'b1;
    for (int i = 0; i < 6; i++) send_char(8'h61 + 8'(i), 1'b0);
    tbuf = 1'b0;
    tick();
    tbuf = 1'b1;
    tick();
    tick();
    checks++;
    if (wrn0 !== 1'b1 || count0 !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset wrn=%b count=%0d required 1 5", wrn0, count0);
    end
    BTND = 1'b1;
    #1;
    cap0.delete(); cap1.delete();
    checks++;
    if (count0 !== 5'd0 || wrn0 !== 1'b0 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset count=%0d wrn=%b empty=%b required 0 0 1", count0, wrn0, empty0);
    end
    tick(); tick();
    BTND = 1'b0;
    tbuf = 1'b0;
    repeat (20) tick();
    checks++;
    if (cap0.size() !== 0) begin
      errors++;
      $display("FAIL no_wrn_after_reset pulses=%0d required 0", cap0.size());
    end
    send_char(8'h55, 1'b0);
    repeat (10) tick();
    checks++;
    if (cap0.size() !== 1 || cap0[0] !== 8'h55) begin
      errors++;
      $display("FAIL echo_after_reset pulses=%0d first=%h required 1 55",
               cap0.size(), (cap0.size() > 0) ? cap0[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_case_swap();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
